// File: rtl/mem_lsu.sv
// Byte-serial load/store sequencer: splits one 32/16/8-bit request into big-endian
// single-byte memory beats, reassembles and extends loads, and reports done/error.
module mem_lsu #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iStart,
  input  logic        iWrite,
  input  logic        iSign,
  input  logic [1:0]  iWidth,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr,
  output logic [31:0] oMemAddr,
  output logic [7:0]  oMemWData,
  output logic        oMemWE,
  output logic        oMemRE,
  input  logic [7:0]  iMemRData
);

  typedef enum logic [2:0] {IDLE, XFER, TAIL, DONE, ERR} state_t;

  state_t      state;
  logic        write_q;
  logic        sign_q;
  logic [1:0]  width_q;
  logic [1:0]  k;
  logic [1:0]  last_k;
  logic [31:0] sreg;
  logic [31:0] acc;

  logic [2:0]  req_beats;
  logic [32:0] req_end;
  logic        req_bad;
  logic [31:0] store_aligned;
  logic [31:0] acc_next;
  logic [31:0] load_ext;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_beats     = 3'd4;
    store_aligned = iData;
    case (iWidth)
      2'b01: begin
        req_beats     = 3'd2;
        store_aligned = {iData[15:0], 16'h0};
      end
      2'b10: begin
        req_beats     = 3'd1;
        store_aligned = {iData[7:0], 24'h0};
      end
      default: ;
    endcase
    // 33-bit end address so a request near 0xFFFFFFFF cannot wrap back into range.
    req_end = {1'b0, iAddr} + 33'(req_beats) - 33'd1;
    req_bad = (iWidth == 2'b11) || (req_end >= 33'(MEM_BYTES)) ||
              (CHECK_ALIGN && (((iWidth == 2'b00) && (iAddr[1:0] != 2'b00)) ||
                               ((iWidth == 2'b01) && iAddr[0])));
  end

  always_comb begin
    acc_next = {acc[23:0], iMemRData};
    case (width_q)
      2'b01:   load_ext = {{16{sign_q & acc_next[15]}}, acc_next[15:0]};
      2'b10:   load_ext = {{24{sign_q & acc_next[7]}}, acc_next[7:0]};
      default: load_ext = acc_next;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      sign_q    <= 1'b0;
      width_q   <= 2'b00;
      k         <= 2'd0;
      last_k    <= 2'd0;
      sreg      <= 32'h0;
      acc       <= 32'h0;
      oData     <= 32'h0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
      oMemAddr  <= 32'h0;
      oMemWData <= 8'h0;
      oMemWE    <= 1'b0;
      oMemRE    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            write_q <= iWrite;
            sign_q  <= iSign;
            width_q <= iWidth;
            oBusy   <= 1'b1;
            if (req_bad) begin
              state <= ERR;
              oDone <= 1'b1;
              oErr  <= 1'b1;
            end else begin
              state    <= XFER;
              k        <= 2'd0;
              last_k   <= 2'(req_beats - 3'd1);
              acc      <= 32'h0;
              oMemAddr <= iAddr;
              oMemWE   <= iWrite;
              oMemRE   <= !iWrite;
              if (iWrite) begin
                oMemWData <= store_aligned[31:24];
                sreg      <= store_aligned << 8;
              end
            end
          end
        end
        XFER: begin
          // Read data lags its beat by one cycle, so beat 0 has nothing to capture yet.
          if (!write_q && (k != 2'd0)) acc <= acc_next;
          if (k == last_k) begin
            oMemWE <= 1'b0;
            oMemRE <= 1'b0;
            if (write_q) begin
              state <= DONE;
              oDone <= 1'b1;
            end else begin
              state <= TAIL;
            end
          end else begin
            k        <= k + 2'd1;
            oMemAddr <= oMemAddr + 32'd1;
            if (write_q) begin
              oMemWData <= sreg[31:24];
              sreg      <= sreg << 8;
            end
          end
        end
        TAIL: begin
          acc   <= acc_next;
          oData <= load_ext;
          oDone <= 1'b1;
          state <= DONE;
        end
        DONE, ERR: begin
          oDone <= 1'b0;
          oErr  <= 1'b0;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table plus scoreboard queues for beats
// and completions, with hand sequences for ignored starts and mid-store reset.
module tb_mem_lsu;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iStart, iWrite, iSign;
  logic [1:0]  iWidth;
  logic [31:0] iAddr, iData;
  logic [31:0] oData;
  logic        oBusy, oDone, oErr;
  logic [31:0] oMemAddr;
  logic [7:0]  oMemWData;
  logic        oMemWE, oMemRE;
  logic [7:0]  iMemRData = 8'h00;

  always #5 clk = ~clk;

  mem_lsu #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iWrite(iWrite), .iSign(iSign),
    .iWidth(iWidth), .iAddr(iAddr), .iData(iData), .oData(oData), .oBusy(oBusy),
    .oDone(oDone), .oErr(oErr), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemWE(oMemWE), .oMemRE(oMemRE), .iMemRData(iMemRData)
  );

  // Synchronous byte memory: read data appears the cycle after the RE beat.
  logic [7:0] mem [MEM_BYTES];
  always @(posedge clk) begin
    if (oMemWE) mem[oMemAddr[9:0]] <= oMemWData;
    if (oMemRE) iMemRData <= mem[oMemAddr[9:0]];
  end

  typedef struct {
    logic        wr;
    logic        sign;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] odata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];
  beat_t mon_b;
  res_t  mon_r;
  bit    mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic int n_beats(input logic [1:0] w);
    return (w == 2'b00) ? 4 : (w == 2'b01) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (oMemWE || oMemRE) begin
        if (beat_q.size() == 0) begin
          fail("beat", $sformatf("got unexpected beat addr=%0h we=%0b re=%0b, expected none",
                                 oMemAddr, oMemWE, oMemRE));
        end else begin
          mon_b = beat_q.pop_front();
          check("beat_we_re_excl", 64'(oMemWE & oMemRE), 64'd0);
          check("beat_we", 64'(oMemWE), 64'(mon_b.we));
          check("beat_addr", 64'(oMemAddr), 64'(mon_b.addr));
          if (mon_b.we) check("beat_wdata", 64'(oMemWData), 64'(mon_b.wdata));
        end
      end
      if (oDone) begin
        if (res_q.size() == 0) begin
          fail("done", $sformatf("got unexpected oDone err=%0b, expected none", oErr));
        end else begin
          mon_r = res_q.pop_front();
          check("done_err", 64'(oErr), 64'(mon_r.err));
          check("done_data", 64'(oData), 64'(mon_r.data));
        end
      end
    end
  end

  task automatic push_expect(input vec_t v, input int n_keep, input bit with_result);
    int n;
    n = n_beats(v.width);
    if (!v.err) begin
      for (int k = 0; k < n && k < n_keep; k++)
        beat_q.push_back('{v.wr, v.addr + 32'(k), 8'(v.data >> (8 * (n - 1 - k)))});
    end
    if (with_result) res_q.push_back('{v.err, v.odata});
  endtask

  // Leaves the bench 1 ns into the first cycle after acceptance, with inputs scrambled.
  task automatic drive_req(input vec_t v);
    iWrite = v.wr;
    iSign  = v.sign;
    iWidth = v.width;
    iAddr  = v.addr;
    iData  = v.data;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    iWrite = 1'($urandom);
    iSign  = 1'($urandom);
    iWidth = 2'($urandom);
    iAddr  = $urandom;
    iData  = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 1; c <= 16 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, 64'(oBusy), 64'd1);
      if (oDone) begin
        seen = 1'b1;
        check({tag, "_latency"}, 64'(c), 64'(exp_lat));
      end
    end
    if (!seen) fail({tag, "_timeout"}, $sformatf("got no oDone within 16 cycles, expected it at C+%0d", exp_lat));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    check({tag, "_idle_busy"}, 64'(oBusy), 64'd0);
    push_expect(v, 4, 1'b1);
    drive_req(v);
    lat = v.err ? 1 : (v.wr ? n_beats(v.width) + 1 : n_beats(v.width) + 2);
    wait_done(lat, tag);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_odata"}, 64'(oData), 64'd0);
    check({tag, "_ctrl"}, 64'({oBusy, oDone, oErr, oMemWE, oMemRE, oMemWData, oMemAddr}), 64'd0);
  endtask

  vec_t vecs[20];
  vec_t va;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'hAAAA_AA80, 1'b0, 32'h1234_5678};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0201, 32'h5555_5501, 1'b0, 32'h1234_5678};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0200, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_0080};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0200, 32'h0,         1'b0, 32'hFFFF_8001};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_8001};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'hDEAD_7FFE, 1'b0, 32'h0000_8001};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0300, 32'h0,         1'b0, 32'h0000_7FFE};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 32'h0000_0101, 32'h0,         1'b1, 32'h0000_7FFE};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 32'h0000_03FE, 32'h0BAD_0BAD, 1'b1, 32'h0000_7FFE};
    vecs[12] = '{1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'h0BAD_0BAD, 1'b1, 32'h0000_7FFE};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_7FFE};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0000_7FFE};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[16] = '{1'b0, 1'b1, 2'b10, 32'h0000_03FD, 32'h0,         1'b0, 32'hFFFF_FFFE};
    vecs[17] = '{1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,         1'b1, 32'hFFFF_FFFE};
    vecs[18] = '{1'b1, 1'b0, 2'b00, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 1'b1, 32'hFFFF_FFFE};
    vecs[19] = '{1'b0, 1'b1, 2'b00, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678};

    rst_n  = 1'b0;
    iStart = 1'b0;
    iWrite = 1'b0;
    iSign  = 1'b0;
    iWidth = 2'b00;
    iAddr  = 32'h0;
    iData  = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Starts during a store and in its DONE cycle must be ignored.
    va = '{1'b1, 1'b0, 2'b00, 32'h0000_0140, 32'hA1B2_C3D4, 1'b0, 32'h1234_5678};
    push_expect(va, 4, 1'b1);
    drive_req(va);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        iStart = 1'b1;
        iWrite = 1'b1;
        iWidth = 2'b10;
        iAddr  = 32'h0000_0180;
        iData  = 32'h0000_005A;
      end
      if (c == 5) check("ignore_done_cycle", 64'(oDone), 64'd1);
      if (c == 6) begin
        check("ignore_idle_busy", 64'(oBusy), 64'd0);
        iStart = 1'b0;
      end
    end
    @(negedge clk);
    check("ignore_beats_left", 64'(beat_q.size()), 64'd0);
    check("ignore_results_left", 64'(res_q.size()), 64'd0);
    run_vec('{1'b0, 1'b0, 2'b00, 32'h0000_0140, 32'h0, 1'b0, 32'hA1B2_C3D4}, "ignore_readback");

    // Reset after the second beat of a word store: only two bytes reach memory.
    run_vec('{1'b1, 1'b0, 2'b01, 32'h0000_0162, 32'h0000_BEEF, 1'b0, 32'hA1B2_C3D4}, "pre_half");
    va = '{1'b1, 1'b0, 2'b00, 32'h0000_0160, 32'h1122_3344, 1'b0, 32'h0};
    push_expect(va, 2, 1'b0);
    drive_req(va);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", 64'(oDone), 64'd0);
    rst_n = 1'b1;
    check("rst_mid_beats_left", 64'(beat_q.size()), 64'd0);
    check("rst_mid_results_left", 64'(res_q.size()), 64'd0);
    @(negedge clk);
    run_vec('{1'b0, 1'b0, 2'b00, 32'h0000_0160, 32'h0, 1'b0, 32'h1122_BEEF}, "rst_readback");

    check("final_beats_left", 64'(beat_q.size()), 64'd0);
    check("final_results_left", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store sequencer on the CPU side of the byte-addressed data memory. It takes one load or store request from the multicycle control unit (32/16/8-bit, signed or unsigned) and performs it as a series of single-byte memory beats in big-endian order. Loads are reassembled and sign- or zero-extended. The block reports completion, or an alignment/range error, to the controller with a one-cycle done pulse.

Parameters:
MEM_BYTES, 1024, size of the byte memory; legal addresses are 0..MEM_BYTES-1.
CHECK_ALIGN, 1, when 1 an unaligned word or half access is an error; when 0 alignment is not checked.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous reset, active low.
iStart  in  1  request strobe; sampled only in IDLE.
iWrite  in  1  1 = store, 0 = load.
iSign  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
iWidth  in  2  access width: 00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = illegal.
iAddr  in  32  byte address of the access (its most-significant byte).
iData  in  32  store data; the low 16 or 8 bits are used for narrow stores.
oData  out  32  extended load result; held until the next successful load.
oBusy  out  1  high from the cycle after acceptance until, and including, the DONE/ERR cycle.
oDone  out  1  one-cycle completion pulse.
oErr  out  1  valid with oDone; 1 = misaligned, out of range, or illegal width.
oMemAddr  out  32  byte address for the current beat.
oMemWData  out  8  write byte for the current beat.
oMemWE  out  1  byte write enable for the current beat.
oMemRE  out  1  byte read enable for the current beat.
iMemRData  in  8  read byte; valid the cycle after the oMemRE beat (synchronous memory).

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE.
  - oData=0, oBusy=0, oDone=0, oErr=0.
  - oMemAddr=0, oMemWData=0, oMemWE=0, oMemRE=0.
  - Beat counter and accumulator cleared.
- Reset mid-operation: the operation is abandoned immediately. Bytes already written stay in memory; no done pulse is issued.
- Beat count N: 4 for width 00, 2 for 01, 1 for 10.
- States: IDLE, XFER, TAIL, DONE, ERR.
- IDLE:
  - When iStart=1, latch iWrite, iSign, iWidth, iAddr and iData, then check the request.
  - It is an error if any of these holds:
    - iWidth=11;
    - CHECK_ALIGN=1 and (width 00 with iAddr[1:0]!=0, or width 01 with iAddr[0]!=0);
    - iAddr+N-1 >= MEM_BYTES, computed without 32-bit wrap.
  - On error go to ERR; otherwise go to XFER with the beat counter k=0.
- XFER: one beat per cycle, k = 0..N-1.
  - oMemAddr = base + k.
  - Store: oMemWE=1. oMemWData is byte (N-1-k) of the latched data, counting from the LSB. Example for a word: k0 = [31:24], k1 = [23:16], k2 = [15:8], k3 = [7:0].
  - Load: oMemRE=1. From the second beat onward, iMemRData is shifted into the accumulator: acc = {acc[23:0], iMemRData}.
  - After beat N-1: a store goes to DONE; a load goes to TAIL.
- TAIL (load only): capture the final byte and drive no memory strobes. Then write oData:
  - width 00: acc;
  - width 01: {16{s & acc[15]}, acc[15:0]};
  - width 10: {24{s & acc[7]}, acc[7:0]}, where s = latched iSign.
  - Go to DONE.
- DONE: oDone=1, oErr=0, then return to IDLE.
- ERR: oDone=1, oErr=1. No WE/RE is ever asserted for the request and oData is unchanged. Return to IDLE.
- Latency from the acceptance cycle C:
  - store: beats in C+1..C+N, oDone in C+N+1;
  - load: beats in C+1..C+N, TAIL in C+N+1, oDone in C+N+2;
  - error: oDone in C+1.
- oMemWE and oMemRE are never high together, and are low outside XFER.
- oMemAddr and oMemWData hold their last value when idle.
- iStart while oBusy=1, or in the DONE/ERR cycle, is ignored; there is no queueing.
- A new request is accepted in the IDLE cycle after the done pulse at the earliest.
- Changes on the request inputs after acceptance have no effect.
- Store does not modify oData.

Test Plan:
- Word store: iAddr=0x100, iData=0x12345678 -> WE beats at 0x100..0x103 carrying 0x12, 0x34, 0x56, 0x78 in cycles C+1..C+4; oDone=1, oErr=0 in C+5.
- Word load: memory 0x100..0x103 = 12 34 56 78 -> RE beats at C+1..C+4; oData=0x12345678 with oDone in C+6.
- Byte load from a location holding 0x80:
  - iSign=1 -> oData=0xFFFFFF80;
  - iSign=0 -> oData=0x00000080.
  - Half load of 0x80 0x01 with iSign=1 -> oData=0xFFFF8001.
- Error cases: half access at 0x101, word access at 0x3FE (MEM_BYTES=1024) and iWidth=11 -> oDone=oErr=1 in C+1, WE/RE never asserted, oData unchanged.
- iStart pulsed during a word store with a different address -> ignored; exactly 4 beats and a single oDone for the original request.
- rst_n dropped after beat 2 of a word store -> all outputs 0 immediately, no oDone; memory holds only the first two bytes; the next request proceeds normally.
